// File: rtl/vga_pkg.sv
// vga_pkg: default 640x480@60 timing constants, frame totals and the shared coordinate type.
package vga_pkg;
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FRONT  = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BACK   = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FRONT  = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BACK   = 33;
   localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   typedef logic [9:0] coord_t;

   // True when v lies in [lo, lo+len-1].
   function automatic logic in_window(input coord_t v, input int lo, input int len);
      return (v >= coord_t'(lo)) && (v < coord_t'(lo + len));
   endfunction
endpackage

// File: rtl/vga_timing_gen_counter.sv
// vga_counter: wrap-around coordinate counter with enable, wrap pulse and next-value lookahead.
module vga_counter
   import vga_pkg::*;
#(
   parameter int MAX = 800
)(
   input  logic   clk,
   input  logic   rst,
   input  logic   i_en,
   output coord_t o_count,
   output coord_t o_next,
   output logic   o_wrap
);
   coord_t r_count;
   logic   w_last;

   assign w_last  = (r_count == coord_t'(MAX - 1));
   assign o_wrap  = i_en & w_last;
   assign o_next  = !i_en ? r_count : (w_last ? '0 : r_count + 10'd1);
   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst)
      if (!rst) r_count <= '0;
      else      r_count <= o_next;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered sync/blank/frame-start outputs.
// Define VGA_CLKDIV_EN to run the pixel tick at half the clk rate.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FRONT  = DEF_H_FRONT,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BACK   = DEF_H_BACK,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FRONT  = DEF_V_FRONT,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BACK   = DEF_V_BACK
)(
   input  logic   clk,
   input  logic   rst,
   output logic   pixel_tick,
   output coord_t pixelx,
   output coord_t pixely,
   output logic   hsync,
   output logic   vsync,
   output logic   video_on,
   output logic   frame_start
);
   localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOT = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   logic   r_tick;
   logic   r_hsync;
   logic   r_vsync;
   logic   r_video;
   logic   r_frame;
   coord_t w_hnext;
   coord_t w_vnext;
   logic   w_hwrap;
   logic   w_vwrap;

   // r_tick doubles as the 1-bit divider when the half-rate pixel clock is enabled.
   always_ff @(posedge clk or negedge rst)
      if (!rst) r_tick <= 1'b0;
`ifdef VGA_CLKDIV_EN
      else      r_tick <= ~r_tick;
`else
      else      r_tick <= 1'b1;
`endif

   vga_counter #(.MAX(H_TOT)) u_hcnt (
      .clk     (clk),
      .rst     (rst),
      .i_en    (r_tick),
      .o_count (pixelx),
      .o_next  (w_hnext),
      .o_wrap  (w_hwrap)
   );

   vga_counter #(.MAX(V_TOT)) u_vcnt (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_hwrap),
      .o_count (pixely),
      .o_next  (w_vnext),
      .o_wrap  (w_vwrap)
   );

   // Decoding the lookahead values keeps these flops aligned with the counters.
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         r_hsync <= 1'b1;
         r_vsync <= 1'b1;
         r_video <= 1'b0;
         r_frame <= 1'b0;
      end else begin
         r_hsync <= !in_window(w_hnext, H_ACTIVE + H_FRONT, H_SYNC);
         r_vsync <= !in_window(w_vnext, V_ACTIVE + V_FRONT, V_SYNC);
         r_video <= (w_hnext < coord_t'(H_ACTIVE)) && (w_vnext < coord_t'(V_ACTIVE));
         r_frame <= w_vwrap;
      end

   assign pixel_tick  = r_tick;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign video_on    = r_video;
   assign frame_start = r_frame;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of line timing on a default instance and frame timing on a small one.
module tb_vga_timing_gen;
`ifdef VGA_CLKDIV_EN
   localparam int CPT = 2;
`else
   localparam int CPT = 1;
`endif
   localparam int SH = 35;
   localparam int SV = 21;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       b_tick, b_hs, b_vs, b_von, b_fs;
   logic [9:0] b_x, b_y;
   logic       s_tick, s_hs, s_vs, s_von, s_fs;
   logic [9:0] s_x, s_y;
   int         cmps = 0;
   int         errs = 0;
   int         cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   vga_timing_gen dut (
      .clk(clk), .rst(rst), .pixel_tick(b_tick), .pixelx(b_x), .pixely(b_y),
      .hsync(b_hs), .vsync(b_vs), .video_on(b_von), .frame_start(b_fs)
   );

   vga_timing_gen #(
      .H_ACTIVE(20), .H_FRONT(4), .H_SYNC(6), .H_BACK(5),
      .V_ACTIVE(12), .V_FRONT(3), .V_SYNC(2), .V_BACK(4)
   ) dut_s (
      .clk(clk), .rst(rst), .pixel_tick(s_tick), .pixelx(s_x), .pixely(s_y),
      .hsync(s_hs), .vsync(s_vs), .video_on(s_von), .frame_start(s_fs)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Step to the negedge just after the next clk edge that carried a pixel tick.
   task automatic adv();
      for (int n = 0; n < 4 && b_tick !== 1'b1; n++) @(negedge clk);
      if (b_tick !== 1'b1) begin
         errs++;
         $error("FAIL tick_wait: observed %0d expected 1", b_tick);
      end
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lo, first, fs, t0, vlo, von, ex, ey;
      lo = 0; first = -1; fs = 0; vlo = 0; von = 0;
      repeat (3) @(negedge clk);
      chk("rst_x", b_x, 0);
      chk("rst_y", b_y, 0);
      chk("rst_hs", b_hs, 1);
      chk("rst_vs", b_vs, 1);
      chk("rst_von", b_von, 0);
      chk("rst_fs", b_fs, 0);
      chk("rst_tick", b_tick, 0);
      chk("rst_s_tick", s_tick, 0);
      rst = 1'b1;
      @(negedge clk);
      chk("tick_after_rst", b_tick, 1);
      chk("hold_before_tick", b_x, 0);
      adv();
      t0 = cyc;
      chk("first_x", b_x, 1);
      chk("first_y", b_y, 0);
      chk("first_von", b_von, 1);
      for (int i = 2; i <= 800; i++) begin
         adv();
         chk("line_x", b_x, i % 800);
         chk("line_y", b_y, i / 800);
         if (b_hs == 1'b0) begin
            if (first < 0) first = int'(b_x);
            lo++;
         end
         if (b_fs) fs++;
         if (b_x == 10'd639) chk("von_639_0", b_von, 1);
         if (b_x == 10'd640) chk("von_640_0", b_von, 0);
      end
      chk("hs_low_count", lo, 96);
      chk("hs_first_x", first, 656);
      chk("no_fs_line", fs, 0);
      adv();
      chk("line2_x", b_x, 1);
      chk("line2_y", b_y, 1);
      chk("line_clks", cyc - t0, 800 * CPT);
      chk("tick_phase", b_tick, CPT == 2 ? 0 : 1);
      @(negedge clk);
      chk("div_hold_x", b_x, CPT == 2 ? 1 : 2);
      rst = 1'b0;
      #1;
      chk("async_x", b_x, 0);
      chk("async_y", b_y, 0);
      chk("async_hs", b_hs, 1);
      chk("async_vs", b_vs, 1);
      chk("async_von", b_von, 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      fs = 0; lo = 0;
      for (int i = 1; i <= SH * SV; i++) begin
         adv();
         ex = i % SH;
         ey = (i / SH) % SV;
         chk("s_x", s_x, ex);
         chk("s_y", s_y, ey);
         chk("s_hs", s_hs, (ex >= 24 && ex <= 29) ? 0 : 1);
         chk("s_vs", s_vs, (ey == 15 || ey == 16) ? 0 : 1);
         chk("s_von", s_von, (ex < 20 && ey < 12) ? 1 : 0);
         chk("s_fs", s_fs, (i == SH * SV) ? 1 : 0);
         if (!s_vs) vlo++;
         if (s_von) von++;
         if (s_fs) fs++;
      end
      chk("s_vs_low_ticks", vlo, 2 * SH);
      chk("s_von_ticks", von, 240);
      chk("s_fs_count", fs, 1);
      chk("s_corner_fs", s_fs, 1);
      chk("s_corner_von", s_von, 1);
      for (int i = 0; i < 6 * SH + 10; i++) adv();
      chk("mid_x", s_x, 10);
      chk("mid_y", s_y, 6);
      chk("mid_von", s_von, 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_x", s_x, 0);
      chk("mid_rst_y", s_y, 0);
      chk("mid_rst_hs", s_hs, 1);
      chk("mid_rst_vs", s_vs, 1);
      chk("mid_rst_von", s_von, 0);
      chk("mid_rst_tick", s_tick, 0);
      repeat (3) @(negedge clk);
      chk("mid_held_x", s_x, 0);
      rst = 1'b1;
      @(negedge clk);
      adv();
      chk("restart_x", s_x, 1);
      chk("restart_y", s_y, 0);
      chk("restart_fs", s_fs, 0);
      chk("restart_von", s_von, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BACK, 33, vertical back porch

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, system clock; the block's only clock
- rst, in, 1, asynchronous reset, active-low
- pixel_tick, out, 1, one-clk pulse marking a pixel advance
- pixelx, out, 10, current horizontal count, 0..799
- pixely, out, 10, current vertical count, 0..524
- hsync, out, 1, horizontal sync, active-low
- vsync, out, 1, vertical sync, active-low
- video_on, out, 1, high while the current pixel is in the visible area
- frame_start, out, 1, one-clk pulse when the counters enter (0,0)

Function
REQ-003 Derived totals SHALL be H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_ACTIVE+V_FRONT+V_SYNC+V_BACK (525).
REQ-004 The counters SHALL update only in cycles where the pixel tick is high, and SHALL hold in all other cycles.
REQ-005 On each tick, pixelx SHALL increment; at H_TOTAL-1 it SHALL wrap to 0.
REQ-006 pixely SHALL increment only on the tick where pixelx wraps; at V_TOTAL-1 it SHALL wrap to 0 on that same tick.
REQ-007 hsync SHALL be 0 for pixelx in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1] ([656,751] by default), and 1 otherwise.
REQ-008 vsync SHALL be 0 for pixely in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1] ([490,491] by default), and 1 otherwise.
REQ-009 video_on SHALL be 1 exactly when pixelx < H_ACTIVE and pixely < V_ACTIVE.
REQ-010 hsync, vsync and video_on SHALL be registered, and computed from the next counter values, so they are cycle-aligned with pixelx/pixely (zero relative latency).
REQ-011 frame_start SHALL be registered high for exactly one clk, in the cycle in which pixelx/pixely first show (0,0) after a wrap; it SHALL NOT fire after reset release.
REQ-012 pixel_tick SHALL expose the internal tick, so downstream stages (sprite renderer, colour output) can share the same enable.

Reset
REQ-013 While rst=0, all outputs SHALL be forced immediately to: pixelx=0, pixely=0, hsync=1, vsync=1, video_on=0, frame_start=0, pixel_tick=0, divider=0.
REQ-014 On the first tick after rst deasserts, the counters SHALL move to (1,0); pixel (0,0) of the first frame therefore stays blanked.
REQ-015 An assertion of rst mid-frame SHALL abort the frame; there SHALL be no partial-line completion.

Configuration
REQ-016 The macro VGA_CLKDIV_EN SHALL control pixel-tick generation:
- when defined, a 1-bit divider toggles every clk, and the tick is high every second clk (50 MHz clk -> 25 MHz pixel rate);
- when undefined, the tick SHALL be constant 1 out of reset, so every clk is a pixel.

Structure
REQ-017 Package vga_pkg SHALL hold:
- the default timing constants;
- H_TOTAL and V_TOTAL;
- the 10-bit coordinate typedef, which the sprite renderer shares.
REQ-018 Sub-module vga_counter SHALL be a parameterised wrap counter with enable, wrap pulse and async active-low reset. It SHALL be instantiated twice: the horizontal instance, enabled by the tick; the vertical instance, enabled by the tick AND the horizontal wrap.

Verification
REQ-019 Reset, then run 800 ticks -> pixelx sequence 1..799,0; pixely goes 0->1 on the wrap tick; hsync low for exactly 96 ticks starting at pixelx=656.
REQ-020 Run one full frame (420000 ticks) -> vsync low for exactly 2 lines (pixely 490,491); frame_start pulses exactly once, with pixelx=pixely=0.
REQ-021 video_on sampling over one frame -> exactly 640*480 = 307200 high ticks; low at (640,0) and at (0,480).
REQ-022 With VGA_CLKDIV_EN defined -> pixel_tick alternates 0,1; counters hold on odd clks; one line = 1600 clk. Undefined -> one line = 800 clk.
REQ-023 Assert rst at (300,200) mid-frame, for 3 clk -> outputs read (0,0), hsync=vsync=1, video_on=0 asynchronously; after release the frame restarts at (1,0).
REQ-024 Corner check at (799,524) -> next tick gives (0,0), frame_start=1, video_on=1, hsync=1, vsync=1, with no intermediate (0,525) or (800,x) value.
